// File: rtl/reg_dump_unit_if.sv
// Register-dump bus bundle: register-file read port plus byte stream to a UART
// transmitter.
//   o_rf_addr / o_rf_read_en / o_rf_out_en / o_rf_write_block : to register file
//   i_rf_data                                                 : register-file data1
//   o_tx_data / o_tx_valid / i_tx_ready                       : byte handshake
// The master modport belongs to the dump unit. The slave modport belongs to the
// register file / transmitter side.
interface reg_dump_unit_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned P_REG_WIDTH = 5
);
  logic [P_REG_WIDTH-1:0] o_rf_addr;
  logic                   o_rf_read_en;
  logic                   o_rf_out_en;
  logic                   o_rf_write_block;
  logic [DATA_WIDTH-1:0]  i_rf_data;
  logic [7:0]             o_tx_data;
  logic                   o_tx_valid;
  logic                   i_tx_ready;

  modport master (
    output o_rf_addr, o_rf_read_en, o_rf_out_en, o_rf_write_block,
    output o_tx_data, o_tx_valid,
    input  i_rf_data, i_tx_ready
  );

  modport slave (
    input  o_rf_addr, o_rf_read_en, o_rf_out_en, o_rf_write_block,
    input  o_tx_data, o_tx_valid,
    output i_rf_data, i_tx_ready
  );
endinterface

// File: rtl/reg_dump_unit.sv
// Register dump unit. It walks registers 0..N_REGS-1 and, for each one, reads
// the word, captures it, and streams it out MSB byte first over a valid/ready
// byte interface.
//   i_clk, i_reset (sync, active-high), i_start : control inputs
//   o_busy, o_done                              : status (o_done is a 1-cycle pulse)
//   bus (reg_dump_unit_if.master)               : register-file and tx signals
// Every output is registered. Each output is computed from the next-state
// values, so it lines up with the state it belongs to.
module reg_dump_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned P_REG_WIDTH = 5,
  parameter int unsigned N_REGS      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  reg_dump_unit_if.master   bus
);

  localparam int unsigned NBYTES = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_READ    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]             r_state;
  logic [P_REG_WIDTH-1:0] r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [DATA_WIDTH-1:0]  r_shadow;

  logic [P_REG_WIDTH-1:0] r_rf_addr;
  logic                   r_rf_read_en;
  logic                   r_rf_out_en;
  logic [7:0]             r_tx_data;
  logic                   r_tx_valid;
  logic                   r_busy;
  logic                   r_done;

  logic [2:0]             w_state_next;
  logic [P_REG_WIDTH-1:0] w_cnt_next;
  logic [IDX_W-1:0]       w_idx_next;
  logic [DATA_WIDTH-1:0]  w_shadow_next;
  logic [7:0]             w_tx_data_next;

  // Byte idx of the word, index 0 being the most significant byte
  function automatic logic [7:0] f_byte(input logic [DATA_WIDTH-1:0] d,
                                        input logic [IDX_W-1:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int unsigned b = 0; b < NBYTES; b++) begin
      if (IDX_W'(b) == idx) r = d[DATA_WIDTH-1-8*b -: 8];
    end
    return r;
  endfunction

  // Next-state logic
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_idx_next    = r_idx;
    w_shadow_next = r_shadow;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_READ;
          w_cnt_next   = '0;
        end
      end
      S_READ: w_state_next = S_CAPTURE;
      S_CAPTURE: begin
        w_shadow_next = bus.i_rf_data;
        w_idx_next    = '0;
        w_state_next  = S_SEND;
      end
      S_SEND: begin
        if (bus.i_tx_ready) begin
          if (r_idx != IDX_W'(NBYTES - 1)) begin
            w_idx_next = r_idx + IDX_W'(1);
          end else if (r_cnt != P_REG_WIDTH'(N_REGS - 1)) begin
            w_cnt_next   = r_cnt + P_REG_WIDTH'(1);
            w_state_next = S_READ;
          end else begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // tx_data is only meaningful in SEND and is held at zero elsewhere
  always_comb begin
    w_tx_data_next = 8'h00;
    if (w_state_next == S_SEND) w_tx_data_next = f_byte(w_shadow_next, w_idx_next);
  end

  // State and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_rf_addr    <= '0;
      r_rf_read_en <= 1'b0;
      r_rf_out_en  <= 1'b0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      r_shadow     <= w_shadow_next;
      r_rf_addr    <= w_cnt_next;
      r_rf_read_en <= (w_state_next == S_READ);
      r_rf_out_en  <= (w_state_next == S_READ) || (w_state_next == S_CAPTURE);
      r_tx_data    <= w_tx_data_next;
      r_tx_valid   <= (w_state_next == S_SEND);
      r_busy       <= (w_state_next != S_IDLE);
      r_done       <= (w_state_next == S_DONE);
    end
  end

  assign bus.o_rf_addr        = r_rf_addr;
  assign bus.o_rf_read_en     = r_rf_read_en;
  assign bus.o_rf_out_en      = r_rf_out_en;
  assign bus.o_rf_write_block = r_busy;
  assign bus.o_tx_data        = r_tx_data;
  assign bus.o_tx_valid       = r_tx_valid;
  assign o_busy               = r_busy;
  assign o_done               = r_done;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Self-checking bench for reg_dump_unit. It uses a cycle-vector table plus
// multi-cycle dump sequences.
module tb_reg_dump_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done;

  reg_dump_unit_if bus ();

  reg_dump_unit dut (
    .i_clk  (clk),
    .i_reset(rst),
    .i_start(start),
    .o_busy (busy),
    .o_done (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Register-file model: synchronous read, output gated by out_en
  logic [31:0] mem [32];
  logic [31:0] rf_q = 32'h0;
  always @(posedge clk) if (bus.o_rf_read_en) rf_q <= mem[bus.o_rf_addr];
  assign bus.i_rf_data = bus.o_rf_out_en ? rf_q : 32'h0;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_byte(input int i);
    logic [31:0] w;
    w = mem[i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  function automatic logic [18:0] outs();
    return {busy, bus.o_rf_write_block, bus.o_rf_read_en, bus.o_rf_out_en,
            bus.o_tx_valid, done, bus.o_rf_addr, bus.o_tx_data};
  endfunction

  typedef struct {
    logic       rst, start, ready;
    logic       busy, rd, oe, valid, dn;
    logic [4:0] addr;
    logic [7:0] data;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(input logic r, input logic s, input logic rd_y,
                              input logic b, input logic rd, input logic oe,
                              input logic v, input logic dn, input logic [4:0] a,
                              input logic [7:0] d);
    vec_t x;
    x.rst = r; x.start = s; x.ready = rd_y; x.busy = b; x.rd = rd; x.oe = oe;
    x.valid = v; x.dn = dn; x.addr = a; x.data = d;
    return x;
  endfunction

  task automatic preload_default;
    for (int k = 0; k < 32; k++) mem[k] = 32'h1000_0000 + 32'(k);
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; bus.i_tx_ready = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  // Full dump with checks on bytes, timing, register-file strobes and status
  task automatic run_dump(input string tag, input bit toggle, input int restart_at);
    int cyc, nbytes, bad_bytes, done_cnt, done_cyc, nread;
    int addr_err, wb_err, oe_err, stab_err, stray;
    logic [4:0] exp_addr;
    logic pv, pr;
    logic [7:0] pd;
    nbytes = 0; bad_bytes = 0; done_cnt = 0; done_cyc = -1; nread = 0;
    addr_err = 0; wb_err = 0; oe_err = 0; stab_err = 0; stray = 0;
    exp_addr = 5'd0; pv = 1'b0; pr = 1'b0; pd = 8'h00;
    bus.i_tx_ready = 1'b1; start = 1'b1;
    tick;
    start = 1'b0; cyc = 1;
    while (cyc < 1500 && (done_cyc < 0 || cyc <= done_cyc + 10)) begin
      bus.i_tx_ready = toggle ? cyc[0] : 1'b1;
      if (bus.o_rf_write_block !== busy) wb_err++;
      if (bus.o_rf_read_en) begin
        nread++;
        if (bus.o_rf_addr !== exp_addr || bus.o_rf_out_en !== 1'b1) addr_err++;
        exp_addr = exp_addr + 5'd1;
      end
      if (bus.o_rf_out_en && (bus.o_tx_valid || !busy)) oe_err++;
      if (bus.o_tx_valid && pv && !pr && bus.o_tx_data !== pd) stab_err++;
      if (bus.o_tx_valid && bus.i_tx_ready) begin
        if (nbytes < 128 && bus.o_tx_data !== exp_byte(nbytes)) bad_bytes++;
        nbytes++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc > done_cyc && (bus.o_tx_valid || busy)) stray++;
      pv = bus.o_tx_valid; pr = bus.i_tx_ready; pd = bus.o_tx_data;
      start = (cyc == restart_at);
      tick;
      cyc++;
    end
    start = 1'b0;
    check({tag, "_timeout"}, 32'(done_cyc < 0), 32'd0);
    check({tag, "_byte_count"}, 32'(nbytes), 32'd128);
    check({tag, "_byte_values"}, 32'(bad_bytes), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_read_count"}, 32'(nread), 32'd32);
    check({tag, "_addr_seq"}, 32'(addr_err), 32'd0);
    check({tag, "_write_block"}, 32'(wb_err), 32'd0);
    check({tag, "_out_en"}, 32'(oe_err), 32'd0);
    check({tag, "_stable"}, 32'(stab_err), 32'd0);
    check({tag, "_idle_after"}, 32'(stray), 32'd0);
    if (!toggle) check({tag, "_done_cycle"}, 32'(done_cyc), 32'd193);
  endtask

  initial begin
    int n, err;
    bus.i_tx_ready = 1'b0;
    preload_default;
    mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'hCAFE_F00D;

    //            rst st rdy busy rd oe v  dn addr   data
    tbl[0]  = mk(0, 0, 0,  0,   0, 0, 0, 0, 5'd0, 8'h00);
    tbl[1]  = mk(0, 1, 0,  1,   1, 1, 0, 0, 5'd0, 8'h00);
    tbl[2]  = mk(0, 0, 0,  1,   0, 1, 0, 0, 5'd0, 8'h00);
    tbl[3]  = mk(0, 0, 1,  1,   0, 0, 1, 0, 5'd0, 8'hDE);
    tbl[4]  = mk(0, 0, 0,  1,   0, 0, 1, 0, 5'd0, 8'hDE);
    tbl[5]  = mk(0, 0, 1,  1,   0, 0, 1, 0, 5'd0, 8'hAD);
    tbl[6]  = mk(0, 0, 0,  1,   0, 0, 1, 0, 5'd0, 8'hAD);
    tbl[7]  = mk(0, 0, 1,  1,   0, 0, 1, 0, 5'd0, 8'hBE);
    tbl[8]  = mk(0, 0, 1,  1,   0, 0, 1, 0, 5'd0, 8'hEF);
    tbl[9]  = mk(0, 0, 1,  1,   1, 1, 0, 0, 5'd1, 8'h00);
    tbl[10] = mk(0, 1, 0,  1,   0, 1, 0, 0, 5'd1, 8'h00);
    tbl[11] = mk(0, 0, 0,  1,   0, 0, 1, 0, 5'd1, 8'hCA);
    tbl[12] = mk(1, 1, 1,  0,   0, 0, 0, 0, 5'd0, 8'h00);
    tbl[13] = mk(0, 0, 1,  0,   0, 0, 0, 0, 5'd0, 8'h00);
    tbl[14] = mk(0, 1, 1,  1,   1, 1, 0, 0, 5'd0, 8'h00);
    tbl[15] = mk(1, 0, 1,  0,   0, 0, 0, 0, 5'd0, 8'h00);

    do_reset;
    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; bus.i_tx_ready = tbl[i].ready;
      tick;
      check($sformatf("vec%0d", i), 32'(outs()),
            32'({tbl[i].busy, tbl[i].busy, tbl[i].rd, tbl[i].oe, tbl[i].valid,
                 tbl[i].dn, tbl[i].addr, tbl[i].data}));
    end

    // Full dump, ready held high
    preload_default;
    do_reset;
    run_dump("dump_rdy1", 1'b0, -1);

    // Toggling ready, reg 5 = DEADBEEF, start re-pulsed mid-dump
    mem[5] = 32'hDEAD_BEEF;
    do_reset;
    run_dump("dump_toggle", 1'b1, 50);

    // Ready held low for 100 cycles in the first SEND
    preload_default;
    do_reset;
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!bus.o_tx_valid && n < 10) begin tick; n++; end
    check("stall_reach_send", 32'(bus.o_tx_valid), 32'd1);
    err = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== 8'h10 || busy !== 1'b1 ||
          bus.o_rf_read_en !== 1'b0) err++;
    end
    check("stall_hold", 32'(err), 32'd0);

    // Reset during SEND of reg 10 byte 2, then restart
    mem[0]  = 32'hDEAD_BEEF;
    mem[10] = 32'h0123_4567;
    do_reset;
    bus.i_tx_ready = 1'b1;
    start = 1'b1; tick; start = 1'b0;
    n = 0; err = 0;
    while (n < 42 && err < 1000) begin
      if (bus.o_tx_valid) n++;
      tick; err++;
    end
    check("abort_at_reg10_b2", 32'({bus.o_tx_valid, bus.o_tx_data}), 32'h145);
    rst = 1'b1; tick;
    check("abort_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    err = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.o_tx_valid || done || busy) err++;
    end
    check("abort_quiet", 32'(err), 32'd0);
    start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!bus.o_tx_valid && n < 10) begin tick; n++; end
    check("restart_first_byte", 32'({bus.o_tx_valid, bus.o_tx_data}), 32'h1DE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
